// File: rtl/lbp_pkg.sv
// lbp_pkg: shared constants, FSM state type and border test for the LBP histogram (LBP_HIST_BORDER_SKIP_EN selects border skipping)
package lbp_pkg;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int ADDR_W = 14;
  localparam int CODE_W = 8;
  localparam int NBINS = 256;
  typedef enum logic [1:0] {ACC, DRAIN, DUMP, DONE} state_t;
  function automatic logic is_border(input logic [ADDR_W-1:0] addr, input int w, input int h);
    int row;
    int col;
    row = int'(addr) / w;
    col = int'(addr) % w;
    return row == 0 || row == h - 1 || col == 0 || col == w - 1;
  endfunction
endpackage

// File: rtl/lbp_hist_ram.sv
// lbp_hist_ram: 256-entry bin store, synchronous write and registered read
module lbp_hist_ram #(
  parameter int CNT_W = 15
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [lbp_pkg::CODE_W-1:0]  wa,
  input  logic [CNT_W-1:0]            wd,
  input  logic [lbp_pkg::CODE_W-1:0]  ra,
  output logic [CNT_W-1:0]            rd
);
  import lbp_pkg::*;
  logic [CNT_W-1:0] mem [NBINS];
  // write the updated bin and register the read; contents are qualified by flags in the parent
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin LBP code histogram for one frame, streamed out over valid/ready (LBP_HIST_BORDER_SKIP_EN drops border pixels)
module lbp_hist #(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int IMG_H = lbp_pkg::IMG_H,
  parameter int CNT_W = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        lbp_valid,
  input  logic [lbp_pkg::ADDR_W-1:0]  lbp_addr,
  input  logic [lbp_pkg::CODE_W-1:0]  lbp_data,
  input  logic                        finish,
  output logic                        hist_valid,
  input  logic                        hist_ready,
  output logic [lbp_pkg::CODE_W-1:0]  hist_bin,
  output logic [CNT_W-1:0]            hist_count,
  output logic                        hist_done
);
  import lbp_pkg::*;
`ifdef LBP_HIST_BORDER_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state;
  logic drain_cnt;
  logic s1_v, w_v;
  logic [CODE_W-1:0] s1_bin, w_bin, rd_addr;
  logic [CNT_W-1:0] w_val, rd_data, base, nxt;
  logic [NBINS-1:0] flag;
  logic accept, fire, fwd;
  assign accept = state == ACC && lbp_valid && !(SKIP && is_border(lbp_addr, IMG_W, IMG_H));
  assign fire = hist_valid && hist_ready;
  // the RAM read for a bin written on the previous edge is stale, so take the last written value
  assign fwd = w_v && w_bin == s1_bin;
  assign base = fwd ? w_val : (flag[s1_bin] ? rd_data : '0);
  assign nxt = base == CNT_MAX ? base : base + 1'b1;
  // prefetch the next bin on a handshake so one bin can be accepted per cycle
  assign rd_addr = state == ACC ? lbp_data : (fire ? hist_bin + 8'd1 : hist_bin);
  assign hist_count = hist_valid && flag[hist_bin] ? rd_data : '0;
  lbp_hist_ram #(.CNT_W(CNT_W)) u_ram (
    .clk (clk),
    .we  (s1_v),
    .wa  (s1_bin),
    .wd  (nxt),
    .ra  (rd_addr),
    .rd  (rd_data)
  );
  // read-modify-write pipeline: stage 1 captures the sample, stage 2 commits the increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v <= 1'b0;
      s1_bin <= '0;
      w_v <= 1'b0;
      w_bin <= '0;
      w_val <= '0;
      flag <= '0;
    end else begin
      s1_v <= accept;
      s1_bin <= lbp_data;
      w_v <= s1_v;
      if (s1_v) begin
        w_bin <= s1_bin;
        w_val <= nxt;
        flag[s1_bin] <= 1'b1;
      end
    end
  end
  // frame control: accumulate, let the pipeline empty, dump bins in order, then hold done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACC;
      drain_cnt <= 1'b0;
      hist_valid <= 1'b0;
      hist_bin <= '0;
      hist_done <= 1'b0;
    end else begin
      case (state)
        ACC: if (finish) state <= DRAIN;
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DUMP;
            hist_valid <= 1'b1;
          end
        end
        DUMP: if (fire) begin
          if (hist_bin == 8'd255) begin
            state <= DONE;
            hist_valid <= 1'b0;
            hist_done <= 1'b1;
          end else hist_bin <= hist_bin + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
